// File: rtl/cam_tag_array.sv
// cam_tag_array: synchronous tag CAM with valid bits, priority hit index,
// free-slot / round-robin allocation and a registered debug read port.
module cam_tag_array #(
    parameter int TAG_W = 8,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             alloc_en,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_addr,
    input  logic             inv_all,
    input  logic             srch_en,
    input  logic [TAG_W-1:0] srch_tag,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic             srch_done,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic [DEPTH-1:0] match_mask,
    output logic             multi_hit,
    output logic             alloc_done,
    output logic [IDX_W-1:0] alloc_idx,
    output logic [TAG_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [IDX_W:0]   count,
    output logic             full
);

    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] match;
    logic [IDX_W-1:0] vptr_q;
    logic [IDX_W-1:0] hit_enc;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] alloc_tgt;
    logic             full_pre;
    logic             do_alloc;
    logic             multi;
    logic [IDX_W:0]   cnt_d;

    // Compare the search argument against every valid entry (pre-edge state).
    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = vld_q[k] && (tag_q[k] == srch_tag);
        end
    end

    // Lowest matching index and lowest free index, scanned high to low.
    always_comb begin
        hit_enc  = '0;
        free_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) hit_enc = IDX_W'(k);
            if (!vld_q[k]) free_idx = IDX_W'(k);
        end
    end

    // More than one bit set: clearing the lowest set bit leaves something.
    always_comb begin
        multi = |(match & (match - DEPTH'(1)));
    end

    // Allocation target and next-state valid bits; write beats invalidate.
    always_comb begin
        full_pre  = &vld_q;
        alloc_tgt = full_pre ? vptr_q : free_idx;
        do_alloc  = alloc_en && !wr_en && !inv_all;
        vld_d     = vld_q;
        if (inv_all) begin
            vld_d = '0;
        end else begin
            if (inv_en) vld_d[inv_addr] = 1'b0;
            if (wr_en) vld_d[wr_addr] = 1'b1;
            else if (alloc_en) vld_d[alloc_tgt] = 1'b1;
        end
    end

    // Population count of the post-edge valid bits.
    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_d = cnt_d + (IDX_W + 1)'(vld_d[k]);
        end
    end

    assign full = (count == (IDX_W + 1)'(DEPTH));

    // Tag storage: not reset, since valid bits alone gate matches.
    always_ff @(posedge clk) begin
        if (!rst && !inv_all) begin
            if (wr_en) tag_q[wr_addr] <= wr_tag;
            else if (alloc_en) tag_q[alloc_tgt] <= wr_tag;
        end
    end

    // Valid bits, victim pointer, counters and registered result ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            vptr_q     <= '0;
            count      <= '0;
            srch_done  <= 1'b0;
            hit        <= 1'b0;
            hit_idx    <= '0;
            match_mask <= '0;
            multi_hit  <= 1'b0;
            alloc_done <= 1'b0;
            alloc_idx  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            count      <= cnt_d;
            srch_done  <= srch_en;
            alloc_done <= do_alloc;
            if (srch_en) begin
                match_mask <= match;
                hit        <= |match;
                hit_idx    <= hit_enc;
                multi_hit  <= multi;
            end
            if (do_alloc) begin
                alloc_idx <= alloc_tgt;
                if (full_pre) vptr_q <= vptr_q + IDX_W'(1);
            end
            if (rd_en) begin
                rd_data  <= tag_q[rd_addr];
                rd_valid <= vld_q[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_cam_tag_array.sv
// tb_cam_tag_array: directed stimulus against a small behavioural model,
// with search results queued at issue and checked when srch_done fires.
module tb_cam_tag_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_tag;
    logic       alloc_en;
    logic       inv_en;
    logic [1:0] inv_addr;
    logic       inv_all;
    logic       srch_en;
    logic [7:0] srch_tag;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic       srch_done;
    logic       hit;
    logic [1:0] hit_idx;
    logic [3:0] match_mask;
    logic       multi_hit;
    logic       alloc_done;
    logic [1:0] alloc_idx;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] count;
    logic       full;

    cam_tag_array #(.TAG_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_tag     (wr_tag),
        .alloc_en   (alloc_en),
        .inv_en     (inv_en),
        .inv_addr   (inv_addr),
        .inv_all    (inv_all),
        .srch_en    (srch_en),
        .srch_tag   (srch_tag),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .srch_done  (srch_done),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .match_mask (match_mask),
        .multi_hit  (multi_hit),
        .alloc_done (alloc_done),
        .alloc_idx  (alloc_idx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .full       (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        logic       hit;
        logic [1:0] idx;
        logic       multi;
    } srch_t;

    srch_t sq[$];

    int total = 0;
    int bad   = 0;

    logic [7:0] mtag [4];
    logic [3:0] mvld;
    logic [1:0] mvptr;
    logic [3:0] e_mask;
    logic       e_hit;
    logic [1:0] e_idx;
    logic       e_multi;
    logic       e_sd;
    logic       e_ad;
    logic [1:0] e_aidx;
    logic [7:0] e_rd;
    logic       e_rv;
    logic [2:0] e_cnt;

    // One comparison: count it, and report observed/expected on mismatch.
    task automatic chk(input string nm, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // Model the cycle from the driven inputs, clock it, then check.
    task automatic cyc();
        srch_t      s;
        logic [3:0] nv;
        logic [1:0] t;
        logic       fp;
        e_sd = srch_en && !rst;
        if (rst) begin
            mvld = '0; mvptr = '0; sq.delete();
            e_mask = '0; e_hit = 0; e_idx = '0; e_multi = 0;
            e_ad = 0; e_aidx = '0; e_rd = '0; e_rv = 0; e_cnt = '0;
        end else begin
            if (srch_en) begin
                s.mask = '0;
                for (int k = 0; k < 4; k++)
                    s.mask[k] = mvld[k] && (mtag[k] == srch_tag);
                s.hit = |s.mask;
                s.idx = '0;
                for (int k = 3; k >= 0; k--)
                    if (s.mask[k]) s.idx = 2'(k);
                s.multi = ($countones(s.mask) > 1);
                sq.push_back(s);
            end
            if (rd_en) begin
                e_rd = mtag[rd_addr];
                e_rv = mvld[rd_addr];
            end
            fp   = &mvld;
            e_ad = alloc_en && !wr_en && !inv_all;
            nv   = mvld;
            if (inv_all) begin
                nv = '0;
            end else begin
                if (inv_en) nv[inv_addr] = 1'b0;
                if (wr_en) begin
                    nv[wr_addr] = 1'b1;
                    mtag[wr_addr] = wr_tag;
                end else if (alloc_en) begin
                    t = mvptr;
                    if (!fp)
                        for (int k = 3; k >= 0; k--)
                            if (!mvld[k]) t = 2'(k);
                    nv[t] = 1'b1;
                    mtag[t] = wr_tag;
                    e_aidx = t;
                    if (fp) mvptr = mvptr + 2'd1;
                end
            end
            mvld  = nv;
            e_cnt = 3'($countones(nv));
        end
        @(posedge clk);
        #1;
        chk("srch_done", srch_done, e_sd);
        if (srch_done === 1'b1) begin
            total++;
            assert (sq.size() > 0) else begin
                bad++;
                $error("FAIL sq_pop observed=empty expected=entry");
            end
            if (sq.size() > 0) begin
                s = sq.pop_front();
                e_mask = s.mask; e_hit = s.hit;
                e_idx = s.idx; e_multi = s.multi;
            end
        end
        chk("match_mask", match_mask, e_mask);
        chk("hit", hit, e_hit);
        chk("hit_idx", hit_idx, e_idx);
        chk("multi_hit", multi_hit, e_multi);
        chk("alloc_done", alloc_done, e_ad);
        chk("alloc_idx", alloc_idx, e_aidx);
        chk("rd_data", rd_data, e_rd);
        chk("rd_valid", rd_valid, e_rv);
        chk("count", count, e_cnt);
        chk("full", full, e_cnt == 3'd4);
        rst = 0; wr_en = 0; alloc_en = 0; inv_en = 0;
        inv_all = 0; srch_en = 0; rd_en = 0;
    endtask

    initial begin
        rst = 1; wr_en = 0; wr_addr = '0; wr_tag = '0;
        alloc_en = 0; inv_en = 0; inv_addr = '0; inv_all = 0;
        srch_en = 0; srch_tag = '0; rd_en = 0; rd_addr = '0;
        cyc();
        rst = 1; cyc();

        srch_en = 1; srch_tag = 8'hFF; cyc();
        chk("rst_srch_hit", hit, 1'b0);
        chk("rst_count", count, 3'd0);

        alloc_en = 1; wr_tag = 8'h11; cyc();
        chk("alloc0", alloc_idx, 2'd0);
        alloc_en = 1; wr_tag = 8'h22; cyc();
        alloc_en = 1; wr_tag = 8'h33; cyc();
        alloc_en = 1; wr_tag = 8'h44; cyc();
        chk("alloc3", alloc_idx, 2'd3);
        chk("full4", full, 1'b1);
        alloc_en = 1; wr_tag = 8'h55; cyc();
        chk("rr_victim0", alloc_idx, 2'd0);
        alloc_en = 1; wr_tag = 8'h66; cyc();
        chk("rr_victim1", alloc_idx, 2'd1);

        wr_en = 1; wr_addr = 2'd1; wr_tag = 8'hA5; cyc();
        wr_en = 1; wr_addr = 2'd3; wr_tag = 8'hA5; cyc();
        srch_en = 1; srch_tag = 8'hA5; cyc();
        chk("a5_mask", match_mask, 4'b1010);
        chk("a5_idx", hit_idx, 2'd1);
        chk("a5_multi", multi_hit, 1'b1);

        wr_en = 1; wr_addr = 2'd2; wr_tag = 8'h22;
        srch_en = 1; srch_tag = 8'h22; cyc();
        chk("rbw_miss", hit, 1'b0);
        srch_en = 1; srch_tag = 8'h22; cyc();
        chk("rbw_hit", hit, 1'b1);
        chk("rbw_idx", hit_idx, 2'd2);

        inv_en = 1; inv_addr = 2'd2; cyc();
        chk("inv_count", count, 3'd3);
        alloc_en = 1; wr_tag = 8'h77; cyc();
        chk("free_slot", alloc_idx, 2'd2);
        alloc_en = 1; wr_tag = 8'h88; cyc();
        chk("vptr_kept", alloc_idx, 2'd2);
        inv_en = 1; inv_addr = 2'd0;
        wr_en = 1; wr_addr = 2'd0; wr_tag = 8'h5A; cyc();
        chk("wr_beats_inv", count, 3'd4);

        wr_en = 1; wr_addr = 2'd3; wr_tag = 8'h99;
        alloc_en = 1; cyc();
        chk("wr_drops_alloc", alloc_done, 1'b0);

        rd_en = 1; rd_addr = 2'd1;
        wr_en = 1; wr_addr = 2'd1; wr_tag = 8'hC3; cyc();
        chk("rd_pre_edge", rd_data, 8'hA5);
        rd_en = 1; rd_addr = 2'd1; cyc();
        chk("rd_new", rd_data, 8'hC3);
        srch_en = 1; srch_tag = 8'h5A; cyc();
        srch_en = 1; srch_tag = 8'h88; cyc();

        inv_all = 1; alloc_en = 1; wr_tag = 8'hEE; cyc();
        chk("inv_all_count", count, 3'd0);
        chk("inv_all_noalloc", alloc_done, 1'b0);
        srch_en = 1; srch_tag = 8'hC3; cyc();
        chk("stale_miss", hit, 1'b0);

        alloc_en = 1; wr_tag = 8'h12; srch_en = 1; srch_tag = 8'h12; cyc();
        rd_en = 1; rd_addr = 2'd0; srch_en = 1; cyc();
        rst = 1; srch_en = 1; srch_tag = 8'h12; cyc();
        chk("rst_sd", srch_done, 1'b0);
        chk("rst_count2", count, 3'd0);
        srch_en = 1; srch_tag = 8'h12; cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_tag_array.md
# cam_tag_array

Synchronous, parametrised tag CAM for the cache tag path. It adds a clock, per-entry valid bits, registered search results with a priority-encoded hit index, and free-slot/round-robin allocation on top of the asynchronous 4×8 CAM behaviour. A registered read port is kept for debug. It sits between the cache controller (allocate/invalidate) and the lookup stage (search).

## Interface
- `TAG_W`, default 8: tag width in bits.
- `DEPTH`, default 4: number of entries; power of 2, ≥2.
- `IDX_W`, default $clog2(DEPTH): index width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: direct write of `wr_tag` to entry `wr_addr`; sets its valid bit.
- `wr_addr` in IDX_W: direct write index.
- `wr_tag` in TAG_W: tag for a direct write or an allocate.
- `alloc_en` in 1: write `wr_tag` into an entry chosen by the block.
- `inv_en` in 1: clear the valid bit of entry `inv_addr`.
- `inv_addr` in IDX_W: invalidate index.
- `inv_all` in 1: clear all valid bits.
- `srch_en` in 1: search request.
- `srch_tag` in TAG_W: search argument.
- `rd_en` in 1: debug read request.
- `rd_addr` in IDX_W: debug read index.
- `srch_done` out 1: pulses one cycle after `srch_en`.
- `hit` out 1: at least one valid entry matched.
- `hit_idx` out IDX_W: lowest matching index; 0 on a miss.
- `match_mask` out DEPTH: bit k = entry k is valid and its tag equals `srch_tag`.
- `multi_hit` out 1: more than one mask bit set (error flag).
- `alloc_done` out 1: pulses one cycle after an accepted allocate.
- `alloc_idx` out IDX_W: entry written by the last allocate.
- `rd_data` out TAG_W: stored tag at `rd_addr`.
- `rd_valid` out 1: valid bit of the entry read.
- `count` out IDX_W+1: number of valid entries.
- `full` out 1: `count == DEPTH`.

## Operation
- Storage: `tag[DEPTH]` (TAG_W bits each), `vld[DEPTH]`, and a victim pointer `vptr` (IDX_W bits).
- Update priority within one cycle, highest first:
  - `inv_all`: all `vld` cleared; every write, allocate and invalidate in that cycle is ignored.
  - `wr_en`: direct write. If `alloc_en` is also high, the allocate is dropped and `alloc_done` stays 0.
  - `alloc_en`.
- `inv_en` applies in the same cycle as a write or allocate. If it targets the entry being written, the write wins and the entry ends valid.
- Allocate target:
  - Not full: the lowest-index entry with `vld == 0`. `vptr` is unchanged.
  - Full: entry `vptr` is overwritten, then `vptr` increments modulo DEPTH.
  - Full-ness is evaluated on pre-cycle state.
- Search:
  - Compare `srch_tag` against all entries using pre-edge contents (read-before-write).
  - Register `match_mask`, `hit`, `hit_idx` and `multi_hit`.
  - Invalid entries never match, whatever their stored tag.
  - Result outputs hold their value until the next search.
- Debug read: registered on `rd_en` and holds otherwise. It returns pre-edge contents.
- `count` is registered and reflects state after the edge. Arithmetic is unsigned, IDX_W+1 bits, with no wrap.
- Reset: all `vld` = 0, `vptr` = 0, and every output = 0. Tag storage is not reset. After reset all entries are invalid, so stale tags cannot produce hits.
- `rst` high mid-operation wins over every other input that cycle. A search issued in the same cycle as reset produces no `srch_done`.

## Timing
- Search latency is 1 cycle: `srch_en` at edge N gives `srch_done` plus results valid after edge N+1. Back-to-back searches are accepted every cycle.
- A write or allocate at edge N is visible to a search issued at edge N+1. A search issued at edge N does not see it.
- Allocate latency is 1 cycle: `alloc_done` and `alloc_idx` update after the same edge that writes the entry.
- `rd_data` and `rd_valid` are valid 1 cycle after `rd_en`.
- There is no backpressure; every request is accepted in the cycle it is presented.
- `full` and `count` change on the edge after the write, allocate or invalidate takes effect.

## Test plan
All scenarios use DEPTH=4, TAG_W=8.
- Reset, then search 0xFF → `srch_done`=1, `hit`=0, `match_mask`=0000, `count`=0.
- Allocate 0x11, 0x22, 0x33, 0x44 → `alloc_idx` = 0, 1, 2, 3; `full`=1. Next allocate 0x55 → writes idx 0 and `vptr`=1. Allocate 0x66 → writes idx 1.
- Direct write 0xA5 to idx 1 and idx 3, then search 0xA5 → `match_mask`=1010, `hit_idx`=1, `multi_hit`=1.
- Search 0x22 in the same cycle as a direct write of 0x22 to idx 2 → miss. The same search repeated on the next cycle → `hit`=1, `hit_idx`=2.
- Fill all 4 entries, then invalidate idx 2 and allocate 0x77 → `alloc_idx`=2, `vptr` unchanged. Then `inv_en` on idx 0 together with `wr_en` to idx 0 → idx 0 ends valid and `count` stays 4.
- Mid-stream: `inv_all` plus `alloc_en` in one cycle → `count`=0 and no `alloc_done`. Then `rst` together with `srch_en` → no `srch_done`, all outputs 0.
